debounce_single_pulser: RTL and testbench
=========================================

Name: debounce_single_pulser

Overview:
- Consumes the synchronized push-button level from the two-flop synchronizer stage; its `din` comes straight from that stage's output.
- Qualifies `din` as stable for `STABLE_CYCLES` consecutive clocks before changing the debounced level.
- Emits one-clock press and release pulses and keeps a wrapping press counter for downstream counter/display logic.
- Whole block runs in the single `clock` domain.

Parameters:
- `STABLE_CYCLES`, 1000: consecutive identical samples needed to accept a level change; legal range 2 to 2^`CNT_W`-1.
- `CNT_W`, 16: width of the internal stability counter.
- `COUNT_W`, 8: width of `press_count`.

Ports:
- `clock` input 1: sole clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `din` input 1: already-synchronized raw button level. Not re-synchronized here.
- `level` output 1: debounced level, registered.
- `press_pulse` output 1: high for exactly one cycle on each accepted 0->1 transition.
- `release_pulse` output 1: high for exactly one cycle on each accepted 1->0 transition.
- `press_count` output `COUNT_W`: number of accepted presses, modulo 2^`COUNT_W`.

Behaviour:
- Reset (sampled `reset`=1 at an edge):
  - state <= S_LOW, cnt <= 0.
  - `level`, `press_pulse`, `release_pulse` <= 0; `press_count` <= 0.
  - `reset` overrides all other activity on that edge.
- States: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK.
- S_LOW:
  - `din`=1 -> S_RISE_CHK, cnt <= 1.
  - Else stay, cnt <= 0.
- S_RISE_CHK:
  - `din`=0 -> S_LOW, cnt <= 0; no output change.
  - `din`=1 and cnt == `STABLE_CYCLES`-1 -> S_HIGH, cnt <= 0, `level` <= 1, `press_pulse` <= 1, `press_count` <= `press_count`+1.
  - `din`=1 otherwise -> cnt <= cnt+1.
- S_HIGH:
  - `din`=0 -> S_FALL_CHK, cnt <= 1.
  - Else stay.
- S_FALL_CHK: mirror of S_RISE_CHK.
  - `din`=1 -> S_HIGH, cnt <= 0.
  - `din`=0 and cnt == `STABLE_CYCLES`-1 -> S_LOW, `level` <= 0, `release_pulse` <= 1; `press_count` unchanged.
  - `din`=0 otherwise -> cnt <= cnt+1.
- Latency:
  - `level` changes on the edge of the `STABLE_CYCLES`-th consecutive sample of the new value.
  - With `STABLE_CYCLES`=4 and `din` first sampled 1 at edge k, `level` and `press_pulse` are 1 after edge k+3.
- Pulses:
  - Default 0 every cycle; asserted only on the accepting edge, so never wider than one cycle.
  - `press_pulse` and `release_pulse` are never high together.
- Any single opposite sample during a CHK state aborts qualification and restarts the count from zero. Bounce shorter than `STABLE_CYCLES` is fully rejected.
- `press_count` wraps: all-ones + 1 -> 0, no saturation, no flag.
- Reset mid-operation (any state, including CHK with cnt>0):
  - Qualification progress is discarded.
  - If `din` is still 1 after reset deasserts, a fresh `STABLE_CYCLES` qualification runs and the press is counted from 0.
- No combinational path from `din` to any output.

Test Plan (`STABLE_CYCLES`=4, `COUNT_W`=4):
- Reset: hold `reset`=1 for 3 cycles with `din`=1 -> `level`=0, both pulses 0, `press_count`=0 throughout.
- Clean press: `din` 0->1, held 10 cycles, first sampled 1 at edge k -> `level`=1 and `press_pulse`=1 after edge k+3 only; `press_pulse`=0 after edge k+4; `press_count`=1.
- Bounce reject: from S_LOW drive `din` pattern 1,1,1,0 repeated 5 times -> `level` stays 0, no pulses, `press_count` unchanged. Repeat the mirrored pattern 0,0,0,1 from S_HIGH -> `level` stays 1, no `release_pulse`.
- Release: from S_HIGH drive `din`=0 for 6 cycles -> `level`=0 and `release_pulse`=1 on the 4th sampling edge, single cycle; `press_count` unchanged.
- Wrap: perform 17 clean press/release pairs -> `press_count` reads 15 after 15 presses, 0 after the 16th, 1 after the 17th. Exactly 17 `press_pulse` and 17 `release_pulse` cycles observed.
- Reset mid-qualification: `din`=1 for 2 edges (cnt=2), assert `reset` 1 cycle, keep `din`=1 -> no pulse during or after the reset cycle until 4 further sampling edges after reset deasserts. Then `press_pulse`=1 once and `press_count`=1.

Source files
------------

// File: rtl/debounce_single_pulser_if.sv
// Signal bundle between a push-button debouncer and its consumer.
// The debouncer takes the slave modport; the consumer/stimulus side takes the master modport.
interface debounce_single_pulser_if #(
    parameter int COUNT_W = 8
);
    logic               din;
    logic               level;
    logic               press_pulse;
    logic               release_pulse;
    logic [COUNT_W-1:0] press_count;

    modport slave (
        input  din,
        output level,
        output press_pulse,
        output release_pulse,
        output press_count
    );

    modport master (
        output din,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );
endinterface

// File: rtl/debounce_single_pulser.sv
// Push-button debouncer: accepts a level change after STABLE_CYCLES identical samples,
// emits one-cycle press/release pulses and keeps a wrapping press counter.
module debounce_single_pulser #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int COUNT_W       = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    debounce_single_pulser_if.slave   bus
);
    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_pulse_q, press_pulse_d;
    logic               release_pulse_q, release_pulse_d;
    logic [COUNT_W-1:0] press_count_q, press_count_d;

    // Next-state and output decode; pulses default low so they can only last one cycle.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        level_d         = level_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        press_count_d   = press_count_q;
        case (state_q)
            S_LOW: begin
                if (bus.din) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            S_RISE_CHK: begin
                if (!bus.din) begin
                    state_d = S_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_HIGH;
                    cnt_d         = CNT_ZERO;
                    level_d       = 1'b1;
                    press_pulse_d = 1'b1;
                    press_count_d = press_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!bus.din) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            S_FALL_CHK: begin
                if (bus.din) begin
                    state_d = S_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = S_LOW;
                    cnt_d           = CNT_ZERO;
                    level_d         = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any qualification in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_LOW;
            cnt_q           <= CNT_ZERO;
            level_q         <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= {COUNT_W{1'b0}};
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            level_q         <= level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_count_q   <= press_count_d;
        end
    end

    assign bus.level         = level_q;
    assign bus.press_pulse   = press_pulse_q;
    assign bus.release_pulse = release_pulse_q;
    assign bus.press_count   = press_count_q;
endmodule

// File: tb/tb_debounce_single_pulser.sv
// Directed bench for debounce_single_pulser with STABLE_CYCLES=4, COUNT_W=4.
module tb_debounce_single_pulser;
    localparam int SC = 4;
    localparam int CW = 4;

    typedef struct {
        logic          rst;
        logic          din;
        logic          lvl;
        logic          pp;
        logic          rp;
        logic [CW-1:0] cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_pp  = 0;
    int   n_rp  = 0;
    vec_t vecs[$];

    debounce_single_pulser_if #(.COUNT_W(CW)) bus ();

    debounce_single_pulser #(
        .STABLE_CYCLES(SC),
        .CNT_W        (16),
        .COUNT_W      (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic add(input int n, input logic r, input logic d, input logic l,
                       input logic p, input logic q, input logic [CW-1:0] c);
        vec_t v;
        v.rst = r; v.din = d; v.lvl = l; v.pp = p; v.rp = q; v.cnt = c;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic d);
        @(negedge clock);
        reset   = r;
        bus.din = d;
        @(posedge clock);
        #1;
        if (bus.press_pulse)   n_pp++;
        if (bus.release_pulse) n_rp++;
    endtask

    task automatic check(input string name, input logic l, input logic p,
                         input logic q, input logic [CW-1:0] c);
        n_vec++;
        if (bus.level !== l || bus.press_pulse !== p || bus.release_pulse !== q ||
            bus.press_count !== c) begin
            n_bad++;
            $display("FAIL %s: got lvl=%b pp=%b rp=%b cnt=%0d, want lvl=%b pp=%b rp=%b cnt=%0d",
                     name, bus.level, bus.press_pulse, bus.release_pulse, bus.press_count,
                     l, p, q, c);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        bus.din = 1'b0;
        // reset held with din high
        add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        // clean press, held 10 samples
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        add(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        add(6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        // release, 6 zero samples
        add(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        add(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        // bounce 1,1,1,0 x5 from low
        for (int i = 0; i < 5; i++) begin
            add(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
            add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        end
        // second press
        add(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        add(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        add(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        // bounce 0,0,0,1 x5 from high
        for (int i = 0; i < 5; i++) begin
            add(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
            add(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        end
        add(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        // reset mid-qualification, din kept high
        add(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        add(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        add(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        add(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        add(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pp, vecs[i].rp, vecs[i].cnt);
        end

        // wrap: 17 clean press/release pairs after a fresh reset
        step(1'b1, 1'b0);
        check("wrap_reset", 1'b0, 1'b0, 1'b0, 4'd0);
        n_pp = 0;
        n_rp = 0;
        for (int p = 1; p <= 17; p++) begin
            logic [CW-1:0] exp_cnt;
            exp_cnt = CW'(p);
            for (int c = 0; c < SC + 1; c++) begin
                step(1'b0, 1'b1);
                if (bus.press_pulse && bus.release_pulse) check_int("pulse_overlap", 1, 0);
            end
            check($sformatf("wrap_press%0d", p), 1'b1, 1'b0, 1'b0, exp_cnt);
            for (int c = 0; c < SC + 1; c++) begin
                step(1'b0, 1'b0);
                if (bus.press_pulse && bus.release_pulse) check_int("pulse_overlap", 1, 0);
            end
            check($sformatf("wrap_release%0d", p), 1'b0, 1'b0, 1'b0, exp_cnt);
        end
        check_int("press_pulses", n_pp, 17);
        check_int("release_pulses", n_rp, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
